// File: rtl/msdf_clk_gen_if.sv
// Configuration port of msdf_clk_gen: valid/ready channel write, apply strobe and reject pulse.
interface msdf_clk_gen_if #(
    parameter int CNT_W = 8,
    parameter int CH_W  = 1
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_phase;
    logic             cfg_update;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_update,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_update,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/msdf_clk_gen.sv
// Runtime-reconfigurable divided/phase-offset clock generator with settle-gated lock.
//   state  | meaning
//   SETTLE | outputs held low, settle counter running, config port closed
//   RUN    | channel counters free-running on the active config, writes accepted
module msdf_clk_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    msdf_clk_gen_if.slave     cfg,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_tick,
    output logic              locked
);
    localparam int SET_W = $clog2(LOCK_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic {SETTLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
    logic             ready, apply, lock_now, accept, legal, wr_ok;
    logic             err_q, locked_q;

    logic [CNT_W-1:0] sh_div [NUM_CH];
    logic [CNT_W-1:0] sh_ph [NUM_CH];
    logic [CNT_W-1:0] sh_div_nxt [NUM_CH];
    logic [CNT_W-1:0] sh_ph_nxt [NUM_CH];
    logic [CNT_W-1:0] act_div [NUM_CH];
    logic [CNT_W-1:0] act_ph [NUM_CH];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        ready          = 1'b0;
        apply          = 1'b0;
        lock_now       = 1'b0;
        case (state)
            SETTLE: begin
                settle_cnt_nxt = settle_cnt + SET_W'(1);
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt      = RUN;
                    settle_cnt_nxt = '0;
                    lock_now       = 1'b1;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (cfg.cfg_update) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                    apply          = 1'b1;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    assign accept = cfg.cfg_valid & ready;
    assign legal  = ({1'b0, cfg.cfg_ch} < (CH_W + 1)'(NUM_CH))
                  & (cfg.cfg_div >= CNT_W'(2))
                  & (cfg.cfg_phase < cfg.cfg_div);
    assign wr_ok  = accept & legal;

    // Same-cycle write lands before the apply copy, so active takes the merged view.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sh_div_nxt[i] = sh_div[i];
            sh_ph_nxt[i]  = sh_ph[i];
            if (wr_ok && cfg.cfg_ch == CH_W'(i)) begin
                sh_div_nxt[i] = cfg.cfg_div;
                sh_ph_nxt[i]  = cfg.cfg_phase;
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_div[i]  <= CNT_W'(2);
                sh_ph[i]   <= '0;
                act_div[i] <= CNT_W'(2);
                act_ph[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_div[i] <= sh_div_nxt[i];
                sh_ph[i]  <= sh_ph_nxt[i];
                if (apply) begin
                    act_div[i] <= sh_div_nxt[i];
                    act_ph[i]  <= sh_ph_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            err_q <= accept & ~legal;
            if (lock_now) begin
                locked_q <= 1'b1;
            end else if (apply) begin
                locked_q <= 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign locked        = locked_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt, cnt_nxt, start, half, last;
        logic             clk_q, tick_q;

        assign half    = act_div[g] >> 1;
        assign last    = act_div[g] - CNT_W'(1);
        // Start at (D-P) mod D so channel lags a P=0 sibling by exactly P cycles.
        assign start   = (act_ph[g] == '0) ? '0 : act_div[g] - act_ph[g];
        assign cnt_nxt = (cnt == last) ? '0 : cnt + CNT_W'(1);

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (lock_now) begin
                cnt    <= start;
                clk_q  <= (start < half);
                tick_q <= (start == last);
            end else if (state == RUN && !apply) begin
                cnt    <= cnt_nxt;
                clk_q  <= (cnt_nxt < half);
                tick_q <= (cnt_nxt == last);
            end else begin
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end
        end

        assign outclk[g]      = clk_q;
        assign outclk_tick[g] = tick_q;
    end
endmodule
